// File: rtl/cmos_capture_pair_if.sv
// Camera-side DVP inputs and the RGB565 pixel stream that feeds the cropping stage.
// The stream has valid but no ready: a pixel is taken on every cam_pclk cycle where
// cmos_frame_valid is high, and the consumer cannot stall it.
interface cmos_capture_pair_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_valid;
  logic [15:0] cmos_frame_data;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data
  );
endinterface

// File: rtl/cmos_capture_pair.sv
// Pairs DVP bytes into RGB565 pixels and discards the first WAIT_FRAME frames after reset.
// Optional macro CMOS_LINE_CHECK_EN adds a per-line pixel count check driving line_err.
module cmos_capture_pair #(
  parameter int WAIT_FRAME = 10,
  parameter int H_PIXELS   = 640
) (
  input  logic                  cam_pclk,
  input  logic                  rst,
  cmos_capture_pair_if.slave    bus,
  output logic                  frame_ready,
  output logic                  line_err
);

  localparam logic [7:0] WAIT_CNT = 8'(WAIT_FRAME);

  if (WAIT_FRAME < 1 || WAIT_FRAME > 255 || H_PIXELS < 1 || H_PIXELS > 2047) begin : g_bad_param
    $error("cmos_capture_pair: WAIT_FRAME or H_PIXELS out of range");
  end

  logic        vsync_d0, vsync_d1;
  logic        href_d0, href_d1;
  logic [7:0]  data_d0;
  logic [7:0]  hi_byte;
  logic        byte_flag;
  logic        valid_r;
  logic [15:0] data_r;
  logic [7:0]  frame_cnt;
  logic        pos_vsync;
  logic        pair_done;

  assign pos_vsync = vsync_d0 & ~vsync_d1;
  // A vsync edge kills the pixel that would complete in the same cycle.
  assign pair_done = href_d0 & byte_flag & ~pos_vsync;

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      vsync_d0    <= 1'b0;
      vsync_d1    <= 1'b0;
      href_d0     <= 1'b0;
      href_d1     <= 1'b0;
      data_d0     <= 8'h00;
      hi_byte     <= 8'h00;
      byte_flag   <= 1'b0;
      valid_r     <= 1'b0;
      data_r      <= 16'h0000;
      frame_cnt   <= 8'h00;
      frame_ready <= 1'b0;
    end else begin
      vsync_d0 <= bus.cam_vsync;
      vsync_d1 <= vsync_d0;
      href_d0  <= bus.cam_href;
      href_d1  <= href_d0;
      data_d0  <= bus.cam_data;

      if (pos_vsync && frame_cnt < WAIT_CNT)
        frame_cnt <= frame_cnt + 8'd1;
      // Ready rises on the vsync that opens frame WAIT_FRAME+1, so that frame is the first one out.
      if (pos_vsync && frame_cnt == WAIT_CNT)
        frame_ready <= 1'b1;

      if (pos_vsync || !href_d0)
        byte_flag <= 1'b0;
      else
        byte_flag <= ~byte_flag;

      if (href_d0 && !byte_flag)
        hi_byte <= data_d0;

      valid_r <= pair_done;
      if (!frame_ready)
        data_r <= 16'h0000;
      else if (pair_done)
        data_r <= {hi_byte, data_d0};
    end
  end

  assign bus.cmos_frame_vsync = vsync_d1 & frame_ready;
  assign bus.cmos_frame_href  = href_d1 & frame_ready;
  assign bus.cmos_frame_valid = valid_r & frame_ready;
  assign bus.cmos_frame_data  = data_r;

`ifdef CMOS_LINE_CHECK_EN
  logic [10:0] pix_cnt;
  logic        pos_href;
  logic        neg_href;

  assign pos_href = href_d0 & ~href_d1;
  assign neg_href = ~href_d0 & href_d1;

  // Counts completed pairs regardless of frame_ready so skipped frames are checked too.
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      pix_cnt  <= 11'd0;
      line_err <= 1'b0;
    end else begin
      if (pos_vsync || pos_href)
        pix_cnt <= 11'd0;
      else if (pair_done && pix_cnt != 11'h7FF)
        pix_cnt <= pix_cnt + 11'd1;

      if (pos_vsync)
        line_err <= 1'b0;
      else if (neg_href && pix_cnt != 11'(H_PIXELS))
        line_err <= 1'b1;
    end
  end
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_capture_pair.sv
// Scoreboard bench for cmos_capture_pair: frame skipping, byte pairing, vsync priority,
// mid-line reset and, when CMOS_LINE_CHECK_EN is defined, the line length flag.
module tb_cmos_capture_pair;

  localparam int WAIT_FRAME = 10;
  localparam int H_PIXELS   = 4;
`ifdef CMOS_LINE_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_ready;
  logic line_err;

  cmos_capture_pair_if bus();

  cmos_capture_pair #(.WAIT_FRAME(WAIT_FRAME), .H_PIXELS(H_PIXELS)) dut (
    .cam_pclk   (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_ready(frame_ready),
    .line_err   (line_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [7:0]  line_q[$];
  int          vs_count = 0;
  bit          ready_m  = 1'b0;
  bit          prev_valid = 1'b0;
  logic [15:0] exp_pix;
  int          exp_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmos_frame_valid) begin
        check("back_to_back", 32'(prev_valid), 32'd0);
        check("href_at_valid", 32'(bus.cmos_frame_href), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_pix = exp_q.pop_front();
          exp_cyc = exp_cyc_q.pop_front();
          check("pixel_data", 32'(bus.cmos_frame_data), 32'(exp_pix));
          check("pixel_cycle", 32'(cyc), 32'(exp_cyc));
        end
      end
      prev_valid = bus.cmos_frame_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    bus.cam_vsync = 1'b1;
    vs_count++;
    ready_m = (vs_count >= WAIT_FRAME + 1);
    tick(3);
    bus.cam_vsync = 1'b0;
    tick(3);
  endtask

  // Each byte is sampled on the next edge; its pixel is visible two edges after driving.
  task automatic send_line();
    logic [7:0] hi;
    int n;
    hi = 8'h00;
    n  = line_q.size();
    for (int i = 0; i < n; i++) begin
      bus.cam_href = 1'b1;
      bus.cam_data = line_q[i];
      if ((i % 2) == 1 && ready_m) begin
        exp_q.push_back({hi, line_q[i]});
        exp_cyc_q.push_back(cyc + 2);
      end
      hi = line_q[i];
      tick(1);
    end
    bus.cam_href = 1'b0;
    bus.cam_data = 8'h00;
    line_q.delete();
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) line_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic full_frame();
    start_frame();
    repeat (2) begin
      fill_rand(8);
      send_line();
      tick(3);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_valid"}, 32'(bus.cmos_frame_valid), 32'd0);
    check({tag, "_href"},  32'(bus.cmos_frame_href), 32'd0);
    check({tag, "_vsync"}, 32'(bus.cmos_frame_vsync), 32'd0);
    check({tag, "_data"},  32'(bus.cmos_frame_data), 32'd0);
    check({tag, "_lerr"},  32'(line_err), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
    rst = 1'b1;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    for (int f = 1; f <= WAIT_FRAME; f++) begin
      full_frame();
      check("skip_ready", 32'(frame_ready), 32'd0);
      check("skip_data", 32'(bus.cmos_frame_data), 32'd0);
    end

    // Frame 11: first frame out.
    start_frame();
    check("ready_set", 32'(frame_ready), 32'd1);
    fill_rand(8);
    send_line();
    tick(3);
    check("line_ok", 32'(line_err), 32'd0);

    fill_rand(6);
    send_line();
    tick(1);
    check("line_err_early", 32'(line_err), 32'd0);
    tick(1);
    check("line_err_set", 32'(line_err), 32'(LC));
    tick(3);
    start_frame();
    check("line_err_clear", 32'(line_err), 32'd0);

    line_q = '{8'hA5, 8'h5A, 8'h12, 8'h34};
    send_line();
    tick(4);
    check("drain_a55a", 32'(exp_q.size()), 32'd0);

    line_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_line();
    tick(3);
    line_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_line();
    tick(4);
    check("drain_odd", 32'(exp_q.size()), 32'd0);

    // vsync rises while the high byte C3 is pending: C3/C4 never pair.
    bus.cam_href = 1'b1;
    bus.cam_data = 8'hC1;
    tick(1);
    bus.cam_data = 8'hC2;
    exp_q.push_back(16'hC1C2);
    exp_cyc_q.push_back(cyc + 2);
    tick(1);
    bus.cam_data = 8'hC3;
    tick(1);
    bus.cam_data  = 8'hC4;
    bus.cam_vsync = 1'b1;
    vs_count++;
    tick(1);
    bus.cam_href = 1'b0;
    bus.cam_data = 8'h00;
    tick(1);
    check("vs_byte_flag", 32'(dut.byte_flag), 32'd0);
`ifdef CMOS_LINE_CHECK_EN
    check("vs_pix_cnt", 32'(dut.pix_cnt), 32'd0);
`endif
    tick(2);
    bus.cam_vsync = 1'b0;
    tick(3);
    fill_rand(8);
    send_line();
    tick(4);
    check("drain_vs", 32'(exp_q.size()), 32'd0);

    // One-cycle reset in the middle of a ready line; the 77/88 pixel is lost.
    bus.cam_href = 1'b1;
    bus.cam_data = 8'h77;
    tick(1);
    bus.cam_data = 8'h88;
    tick(1);
    rst = 1'b1;
    bus.cam_data = 8'h99;
    tick(1);
    rst = 1'b0;
    bus.cam_href = 1'b0;
    bus.cam_data = 8'h00;
    check_outputs_zero("midrst");
    vs_count = 0;
    ready_m  = 1'b0;
    tick(2);

    for (int f = 1; f <= WAIT_FRAME; f++) begin
      full_frame();
      check("reskip_ready", 32'(frame_ready), 32'd0);
    end
    full_frame();
    check("reready", 32'(frame_ready), 32'd1);

    tick(5);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    check("watchdog", 32'd1, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
